// File: rtl/reg_status_table.sv
// reg_status_table: architectural register file plus producer-tag table for a
// Tomasulo-style core. Each of the 32 registers holds a 32-bit value and a
// 5-bit producer tag. Tag 0 means the value is valid.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_reg_1/2          read port register indices (registered, 1-cycle latency)
//   in_bank_enable/reg/tag   rename: mark in_bank_tag as producer of in_bank_reg
//   in_CDB_broadcast/tag/val common data bus result broadcast
//   out_enable          read outputs valid (1 on every cycle after reset release)
//   out_val_1/2         operand value per read port
//   out_tag_1/2         pending producer tag per read port (0 = value valid)
//
// Optional feature (macro REGSTAT_RENAME_FWD_EN): a read of the register being
// renamed in the same cycle returns the new tag, taking priority over CDB
// forwarding. With the macro undefined the read returns the pre-rename state.
module reg_status_table (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  in_reg_1,
   input  logic [4:0]  in_reg_2,
   input  logic        in_bank_enable,
   input  logic [4:0]  in_bank_reg,
   input  logic [4:0]  in_bank_tag,
   input  logic        in_CDB_broadcast,
   input  logic [4:0]  in_CDB_tag,
   input  logic [31:0] in_CDB_val,
   output logic        out_enable,
   output logic [31:0] out_val_1,
   output logic [31:0] out_val_2,
   output logic [4:0]  out_tag_1,
   output logic [4:0]  out_tag_2
);

   localparam int unsigned NREG = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned TW   = 5;
   localparam int unsigned AW   = 5;

   logic [DW-1:0] vals [NREG];
   logic [TW-1:0] tags [NREG];

   logic          cdb_valid_c;
   logic          rename_valid_c;
   logic [DW-1:0] rd_val_1_c;
   logic [DW-1:0] rd_val_2_c;
   logic [TW-1:0] rd_tag_1_c;
   logic [TW-1:0] rd_tag_2_c;

   // Tag 0 broadcasts and renames of r0 are no-ops.
   assign cdb_valid_c    = in_CDB_broadcast && (in_CDB_tag != '0);
   assign rename_valid_c = in_bank_enable && (in_bank_reg != '0);

   // Read port 1: stored state, overridden by a matching CDB broadcast.
   always_comb begin
      rd_val_1_c = vals[in_reg_1];
      rd_tag_1_c = tags[in_reg_1];
      if (cdb_valid_c && (tags[in_reg_1] == in_CDB_tag)) begin
         rd_val_1_c = in_CDB_val;
         rd_tag_1_c = '0;
      end
`ifdef REGSTAT_RENAME_FWD_EN
      if (rename_valid_c && (in_bank_reg == in_reg_1)) begin
         rd_tag_1_c = in_bank_tag;
      end
`endif
   end

   // Read port 2: same selection as port 1.
   always_comb begin
      rd_val_2_c = vals[in_reg_2];
      rd_tag_2_c = tags[in_reg_2];
      if (cdb_valid_c && (tags[in_reg_2] == in_CDB_tag)) begin
         rd_val_2_c = in_CDB_val;
         rd_tag_2_c = '0;
      end
`ifdef REGSTAT_RENAME_FWD_EN
      if (rename_valid_c && (in_bank_reg == in_reg_2)) begin
         rd_tag_2_c = in_bank_tag;
      end
`endif
   end

   // Table update. r0 is never written after reset, so it stays 0/0.
   // Rename is applied after the CDB retire so it wins the tag on collision,
   // while the value still picks up the broadcast result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            vals[i] <= '0;
            tags[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < NREG; i++) begin
            if (cdb_valid_c && (tags[i] == in_CDB_tag)) begin
               vals[i] <= in_CDB_val;
               tags[i] <= '0;
            end
            if (rename_valid_c && (in_bank_reg == AW'(i))) begin
               tags[i] <= in_bank_tag;
            end
         end
      end
   end

   // Registered read outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_enable <= 1'b0;
         out_val_1  <= '0;
         out_val_2  <= '0;
         out_tag_1  <= '0;
         out_tag_2  <= '0;
      end else begin
         out_enable <= 1'b1;
         out_val_1  <= rd_val_1_c;
         out_val_2  <= rd_val_2_c;
         out_tag_1  <= rd_tag_1_c;
         out_tag_2  <= rd_tag_2_c;
      end
   end

endmodule

// File: tb/tb_reg_status_table.sv
// Directed, table-driven bench for reg_status_table (default build).
// Each vector gives the inputs applied before a rising edge and the outputs
// expected right after that edge.
module tb_reg_status_table;

   logic        clk;
   logic        rst_n;
   logic [4:0]  in_reg_1;
   logic [4:0]  in_reg_2;
   logic        in_bank_enable;
   logic [4:0]  in_bank_reg;
   logic [4:0]  in_bank_tag;
   logic        in_CDB_broadcast;
   logic [4:0]  in_CDB_tag;
   logic [31:0] in_CDB_val;
   logic        out_enable;
   logic [31:0] out_val_1;
   logic [31:0] out_val_2;
   logic [4:0]  out_tag_1;
   logic [4:0]  out_tag_2;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rst;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        ben;
      logic [4:0]  breg;
      logic [4:0]  btag;
      logic        cb;
      logic [4:0]  ctag;
      logic [31:0] cval;
      logic        e_en;
      logic [31:0] e_v1;
      logic [4:0]  e_t1;
      logic [31:0] e_v2;
      logic [4:0]  e_t2;
   } vec_t;

   vec_t vq[$];

   reg_status_table dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_reg_1         (in_reg_1),
      .in_reg_2         (in_reg_2),
      .in_bank_enable   (in_bank_enable),
      .in_bank_reg      (in_bank_reg),
      .in_bank_tag      (in_bank_tag),
      .in_CDB_broadcast (in_CDB_broadcast),
      .in_CDB_tag       (in_CDB_tag),
      .in_CDB_val       (in_CDB_val),
      .out_enable       (out_enable),
      .out_val_1        (out_val_1),
      .out_val_2        (out_val_2),
      .out_tag_1        (out_tag_1),
      .out_tag_2        (out_tag_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                      input logic ben, input logic [4:0] breg, input logic [4:0] btag,
                      input logic cb, input logic [4:0] ctag, input logic [31:0] cval,
                      input logic e_en, input logic [31:0] e_v1, input logic [4:0] e_t1,
                      input logic [31:0] e_v2, input logic [4:0] e_t2);
      vec_t v;
      v.rst = rst; v.r1 = r1; v.r2 = r2; v.ben = ben; v.breg = breg; v.btag = btag;
      v.cb = cb; v.ctag = ctag; v.cval = cval; v.e_en = e_en;
      v.e_v1 = e_v1; v.e_t1 = e_t1; v.e_v2 = e_v2; v.e_t2 = e_t2;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      rst_n            = v.rst;
      in_reg_1         = v.r1;
      in_reg_2         = v.r2;
      in_bank_enable   = v.ben;
      in_bank_reg      = v.breg;
      in_bank_tag      = v.btag;
      in_CDB_broadcast = v.cb;
      in_CDB_tag       = v.ctag;
      in_CDB_val       = v.cval;
   endtask

   task automatic step_and_check(input vec_t v, input string tagname);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
      check({tagname, ".en"}, 32'(out_enable), 32'(v.e_en));
      check({tagname, ".v1"}, out_val_1, v.e_v1);
      check({tagname, ".t1"}, 32'(out_tag_1), 32'(v.e_t1));
      check({tagname, ".v2"}, out_val_2, v.e_v2);
      check({tagname, ".t2"}, 32'(out_tag_2), 32'(v.e_t2));
   endtask

   initial begin
      vec_t h;
      // Hand sequence: reset held two cycles with activity on the inputs.
      h = '{rst:0, r1:5, r2:1, ben:1, breg:5, btag:1, cb:1, ctag:1, cval:32'h77,
            e_en:0, e_v1:0, e_t1:0, e_v2:0, e_t2:0};
      drive(h);
      step_and_check(h, "rst0");
      step_and_check(h, "rst1");

      //  rst r1  r2  ben breg btag cb ctag cval        en v1          t1 v2          t2
      add(1, 5,  1,  0,  0,   0,  0, 0,  32'h0,      1, 32'h0,      0, 32'h0,      0); // 0 release
      add(1, 5,  1,  1,  5,   1,  0, 0,  32'h0,      1, 32'h0,      0, 32'h0,      0); // 1 rename r5->1, pre-rename read
      add(1, 5,  1,  0,  0,   0,  0, 0,  32'h0,      1, 32'h0,      1, 32'h0,      0); // 2 r5 tag 1
      add(1, 5,  1,  0,  0,   0,  1, 1,  32'h111,    1, 32'h111,    0, 32'h0,      0); // 3 CDB forward
      add(1, 5,  1,  0,  0,   0,  0, 0,  32'h0,      1, 32'h111,    0, 32'h0,      0); // 4 retired
      add(1, 1,  2,  1,  5,   1,  0, 0,  32'h0,      1, 32'h0,      0, 32'h0,      0); // 5 rename r5->1 again
      add(1, 1,  2,  0,  0,   0,  1, 1,  32'h7,      1, 32'h0,      0, 32'h0,      0); // 6 CDB tag1 val7
      add(1, 5,  1,  0,  0,   0,  0, 0,  32'h0,      1, 32'h7,      0, 32'h0,      0); // 7 r5=7, r1 untouched
      add(1, 3,  5,  1,  3,   2,  0, 0,  32'h0,      1, 32'h0,      0, 32'h7,      0); // 8 rename r3->2
      add(1, 3,  5,  1,  3,   4,  1, 2,  32'h9,      1, 32'h9,      0, 32'h7,      0); // 9 collision
      add(1, 3,  0,  0,  0,   0,  0, 0,  32'h0,      1, 32'h9,      4, 32'h0,      0); // 10 r3 val9 tag4
      add(1, 0,  3,  0,  0,   0,  1, 4,  32'h5,      1, 32'h0,      0, 32'h5,      0); // 11 CDB tag4 fwd
      add(1, 3,  3,  0,  0,   0,  0, 0,  32'h0,      1, 32'h5,      0, 32'h5,      0); // 12 r3 val5
      add(1, 0,  0,  1,  0,   3,  0, 0,  32'h0,      1, 32'h0,      0, 32'h0,      0); // 13 rename r0 ignored
      add(1, 0,  0,  0,  0,   0,  1, 3,  32'hFF,     1, 32'h0,      0, 32'h0,      0); // 14 CDB tag3
      add(1, 0,  0,  0,  0,   0,  0, 0,  32'h0,      1, 32'h0,      0, 32'h0,      0); // 15 r0 still 0
      add(1, 6,  7,  1,  6,   2,  0, 0,  32'h0,      1, 32'h0,      0, 32'h0,      0); // 16 r6->2
      add(1, 6,  7,  1,  7,   2,  0, 0,  32'h0,      1, 32'h0,      2, 32'h0,      0); // 17 r7->2
      add(1, 6,  7,  0,  0,   0,  0, 0,  32'h0,      1, 32'h0,      2, 32'h0,      2); // 18 both tag2
      add(1, 6,  7,  0,  0,   0,  1, 2,  32'hA,      1, 32'hA,      0, 32'hA,      0); // 19 multi-match fwd
      add(1, 6,  7,  0,  0,   0,  0, 0,  32'h0,      1, 32'hA,      0, 32'hA,      0); // 20 both retired
      add(1, 8,  3,  0,  0,   0,  1, 0,  32'h55,     1, 32'h0,      0, 32'h5,      0); // 21 tag0 bcast ignored
      add(1, 8,  9,  0,  0,   0,  0, 0,  32'h0,      1, 32'h0,      0, 32'h0,      0); // 22 r8 unwritten
      add(1, 6,  0,  1,  6,   9,  0, 0,  32'h0,      1, 32'hA,      0, 32'h0,      0); // 23 r6->9
      add(1, 6,  0,  1,  6,   0,  0, 0,  32'h0,      1, 32'hA,      9, 32'h0,      0); // 24 rename tag0
      add(1, 6,  0,  0,  0,   0,  0, 0,  32'h0,      1, 32'hA,      0, 32'h0,      0); // 25 r6 ready

      foreach (vq[i]) begin
         step_and_check(vq[i], $sformatf("vec%0d", i));
      end

      // Hand sequence: reset mid-operation overrides rename and CDB writes.
      h = '{rst:0, r1:5, r2:9, ben:1, breg:9, btag:5, cb:1, ctag:9, cval:32'h33,
            e_en:0, e_v1:0, e_t1:0, e_v2:0, e_t2:0};
      step_and_check(h, "midrst");
      h = '{rst:1, r1:5, r2:9, ben:0, breg:0, btag:0, cb:0, ctag:0, cval:32'h0,
            e_en:1, e_v1:0, e_t1:0, e_v2:0, e_t2:0};
      step_and_check(h, "postrst");
      h = '{rst:1, r1:6, r2:3, ben:0, breg:0, btag:0, cb:1, ctag:5, cval:32'h44,
            e_en:1, e_v1:0, e_t1:0, e_v2:0, e_t2:0};
      step_and_check(h, "postrst2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
